// File: rtl/dcpu2.sv
// dcpu2 - 16-bit dcpu core, second generation.
//
// 16x16 register file (R13 = ST, R14 = SP, R15 = PC). One single-port memory
// bus with i_ack wait states. Ascending stack. Maskable, prioritised interrupts
// with a one-hot acknowledge pulse, and reti.
//
// ST layout: [0]=Z, [1]=C, [2]=IE, [3 +: IRQ_W]=interrupt mask.
//
// Optional feature macro: DCPU_HALT_EN
//   defined   : opcode 16'hFFFF halts the core until an unmasked irq is
//               pending, whatever IE says.
//   undefined : 16'hFFFF is a NOP and o_halt is tied low.
//
// Ports
//   i_clk      clock, all state on rising edge
//   i_reset_n  asynchronous active-low reset
//   i_dat      bus read data, valid with i_ack
//   o_dat      bus write data
//   o_addr     bus address
//   o_we       write strobe, qualified by o_cs
//   o_cs       bus request, held until i_ack
//   i_ack      bus transfer completes this cycle
//   i_irq      level-sensitive interrupt requests (line 0 highest priority)
//   o_irq_ack  one-hot, 1-cycle pulse of the serviced line
//   o_halt     core halted
//
// state | meaning
// FETCH | read opcode at PC, or divert to INT when an enabled irq is pending
// EXEC  | execute r_op; bus ops stay here until i_ack
// INT   | push PC at SP, then vector to INT_VEC with IE cleared
// HALT  | idle with bus released until an unmasked irq appears (macro only)

module dcpu2 #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] INT_VEC   = 16'h0002,
    parameter int          IRQ_W     = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [15:0]      i_dat,
    output logic [15:0]      o_dat,
    output logic [15:0]      o_addr,
    output logic             o_we,
    output logic             o_cs,
    input  logic             i_ack,
    input  logic [IRQ_W-1:0] i_irq,
    output logic [IRQ_W-1:0] o_irq_ack,
    output logic             o_halt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_INT   = 2'd2
`ifdef DCPU_HALT_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_t;

    localparam logic [IRQ_W-1:0] IRQ_ONE = IRQ_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_regs [16];
    logic [15:0]      r_op;
    logic [IRQ_W-1:0] r_irq_pend;

    logic [15:0]      w_pc;
    logic [15:0]      w_sp;
    logic             w_z;
    logic             w_c;
    logic             w_ie;
    logic [IRQ_W-1:0] w_mask;
    logic             w_irq_take;

    logic [3:0]       w_d;
    logic [15:0]      w_rd;
    logic [15:0]      w_rs;
    logic [15:0]      w_mem_addr;
    logic [15:0]      w_rjp_off;
    logic             w_cond;

    logic             w_is_ldi;
    logic             w_is_ldh;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_is_rjp;
    logic             w_is_jp;
    logic             w_is_br;
    logic             w_is_ret;
    logic             w_is_reti;
`ifdef DCPU_HALT_EN
    logic             w_is_halt;
    logic             w_halt;
`endif

    logic             w_cs;
    logic             w_we;
    logic [15:0]      w_addr;
    logic [15:0]      w_dout;
    logic [IRQ_W-1:0] w_irq_ack;

    assign w_pc   = r_regs[15];
    assign w_sp   = r_regs[14];
    assign w_z    = r_regs[13][0];
    assign w_c    = r_regs[13][1];
    assign w_ie   = r_regs[13][2];
    assign w_mask = r_regs[13][3 +: IRQ_W];

    assign w_irq_take = w_ie && (|(i_irq & w_mask));

    // Decode of the latched opcode
    assign w_d        = r_op[3:0];
    assign w_rd       = r_regs[r_op[3:0]];
    assign w_rs       = r_regs[r_op[7:4]];
    assign w_mem_addr = w_rs + {{11{r_op[12]}}, r_op[12:8]};
    // rjp offset is split around the cond field: o[8:4] in [11:7], o[3:0] in [3:0]
    assign w_rjp_off  = {{7{r_op[11]}}, r_op[11:7], r_op[3:0]};

    assign w_is_ldi  = (r_op[15:14] == 2'b00);
    assign w_is_ldh  = (r_op[15:14] == 2'b01);
    assign w_is_ld   = (r_op[15:13] == 3'b100);
    assign w_is_st   = (r_op[15:13] == 3'b101);
    assign w_is_rjp  = (r_op[15:12] == 4'b1100);
    // cond code 7 in the D0 group selects ret rather than a jump
    assign w_is_ret  = (r_op[15:8] == 8'hD0) && (r_op[6:4] == 3'b111);
    assign w_is_reti = (r_op[15:8] == 8'hD1) && (r_op[6:4] == 3'b111);
    assign w_is_jp   = (r_op[15:8] == 8'hD0) && !r_op[7] && (r_op[6:4] != 3'b111);
    assign w_is_br   = (r_op[15:8] == 8'hD0) &&  r_op[7] && (r_op[6:4] != 3'b111);
`ifdef DCPU_HALT_EN
    assign w_is_halt = (r_op == 16'hFFFF);
`endif

    always_comb begin
        w_cond = 1'b0;
        case (r_op[6:4])
            3'd0:    w_cond = 1'b1;
            3'd1:    w_cond = w_z;
            3'd2:    w_cond = ~w_z;
            3'd3:    w_cond = w_c;
            3'd4:    w_cond = ~w_c;
            default: w_cond = 1'b0;
        endcase
    end

    // Lowest set bit of the latched pending vector = highest priority line
    assign w_irq_ack = ((r_state == S_INT) && i_ack)
                       ? (r_irq_pend & (~r_irq_pend + IRQ_ONE))
                       : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_addr      = 16'h0000;
        w_dout      = 16'h0000;
`ifdef DCPU_HALT_EN
        w_halt      = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                if (w_irq_take) begin
                    w_state_nxt = S_INT;
                end else begin
                    w_cs   = 1'b1;
                    w_addr = w_pc;
                    if (i_ack) begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (w_is_ld) begin
                    w_cs   = 1'b1;
                    w_addr = w_mem_addr;
                end else if (w_is_st) begin
                    w_cs   = 1'b1;
                    w_we   = 1'b1;
                    w_addr = w_mem_addr;
                    w_dout = w_rd;
                end else if (w_is_br && w_cond) begin
                    w_cs   = 1'b1;
                    w_we   = 1'b1;
                    w_addr = w_sp;
                    w_dout = w_pc;
                end else if (w_is_ret || w_is_reti) begin
                    w_cs   = 1'b1;
                    w_addr = w_sp - 16'd1;
                end
`ifdef DCPU_HALT_EN
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else
`endif
                if (!w_cs || i_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_INT: begin
                w_cs   = 1'b1;
                w_we   = 1'b1;
                w_addr = w_sp;
                w_dout = w_pc;
                if (i_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
`ifdef DCPU_HALT_EN
            S_HALT: begin
                w_halt = 1'b1;
                // wake on any unmasked request; FETCH then decides on IE
                if (|(i_irq & w_mask)) begin
                    w_state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_regs[15] <= RESET_VEC;
            r_op       <= 16'h0000;
            r_irq_pend <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_irq_take) begin
                        // requests that drop while INT waits on the bus are still serviced
                        r_irq_pend <= i_irq & w_mask;
                    end else if (i_ack) begin
                        r_op       <= i_dat;
                        r_regs[15] <= w_pc + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (w_is_ldi) begin
                        r_regs[w_d] <= {6'h00, r_op[13:4]};
                    end else if (w_is_ldh) begin
                        r_regs[w_d] <= {r_op[11:4], w_rd[7:0]};
                    end else if (w_is_ld) begin
                        if (i_ack) begin
                            r_regs[w_d] <= i_dat;
                        end
                    end else if (w_is_rjp) begin
                        if (w_cond) begin
                            r_regs[15] <= w_pc + w_rjp_off;
                        end
                    end else if (w_is_jp) begin
                        if (w_cond) begin
                            r_regs[15] <= w_rd;
                        end
                    end else if (w_is_br) begin
                        if (w_cond && i_ack) begin
                            r_regs[14] <= w_sp + 16'd1;
                            r_regs[15] <= w_rd;
                        end
                    end else if (w_is_ret || w_is_reti) begin
                        if (i_ack) begin
                            r_regs[14] <= w_sp - 16'd1;
                            r_regs[15] <= i_dat;
                            if (w_is_reti) begin
                                r_regs[13][2] <= 1'b1;
                            end
                        end
                    end
                end
                S_INT: begin
                    if (i_ack) begin
                        r_regs[14]    <= w_sp + 16'd1;
                        r_regs[13][2] <= 1'b0;
                        r_regs[15]    <= INT_VEC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and status outputs are forced low for as long as reset is held,
    // which also aborts an in-flight transfer in the cycle reset arrives.
    assign o_cs      = i_reset_n & w_cs;
    assign o_we      = i_reset_n & w_we;
    assign o_addr    = i_reset_n ? w_addr : 16'h0000;
    assign o_dat     = i_reset_n ? w_dout : 16'h0000;
    assign o_irq_ack = i_reset_n ? w_irq_ack : '0;
`ifdef DCPU_HALT_EN
    assign o_halt    = i_reset_n & w_halt;
`else
    assign o_halt    = 1'b0;
`endif

endmodule

// File: tb/tb_dcpu2.sv
// Directed bench for dcpu2: small program in a bench-side memory whose
// responder adds three wait states to any access at address 0x00FF.
module tb_dcpu2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_dat;
    logic [15:0] o_dat;
    logic [15:0] o_addr;
    logic        o_we;
    logic        o_cs;
    logic        i_ack;
    logic [3:0]  i_irq;
    logic [3:0]  o_irq_ack;
    logic        o_halt;

    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          wcnt   = 0;

    always #5 clk = ~clk;

    dcpu2 #(
        .RESET_VEC (16'h0000),
        .INT_VEC   (16'h0300),
        .IRQ_W     (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_dat     (i_dat),
        .o_dat     (o_dat),
        .o_addr    (o_addr),
        .o_we      (o_we),
        .o_cs      (o_cs),
        .i_ack     (i_ack),
        .i_irq     (i_irq),
        .o_irq_ack (o_irq_ack),
        .o_halt    (o_halt)
    );

    function automatic logic [15:0] f_ldi(input logic [9:0] imm, input logic [3:0] d);
        return {2'b00, imm, d};
    endfunction
    function automatic logic [15:0] f_ldh(input logic [7:0] imm, input logic [3:0] d);
        return {2'b01, 2'b00, imm, d};
    endfunction
    function automatic logic [15:0] f_ld(input logic [4:0] o, input logic [3:0] s, input logic [3:0] d);
        return {3'b100, o, s, d};
    endfunction
    function automatic logic [15:0] f_st(input logic [4:0] o, input logic [3:0] s, input logic [3:0] d);
        return {3'b101, o, s, d};
    endfunction
    function automatic logic [15:0] f_rjp(input logic [8:0] o, input logic [2:0] c);
        return {4'b1100, o[8:4], c, o[3:0]};
    endfunction
    function automatic logic [15:0] f_jp(input logic [2:0] c, input logic [3:0] d);
        return {8'hD0, 1'b0, c, d};
    endfunction
    function automatic logic [15:0] f_br(input logic [2:0] c, input logic [3:0] d);
        return {8'hD0, 1'b1, c, d};
    endfunction

    // Memory responder: decides i_ack/i_dat on the falling edge.
    initial begin
        i_ack = 1'b0;
        i_dat = 16'h0000;
        forever begin
            @(negedge clk);
            if (i_ack || !o_cs || !rst_n) wcnt = 0;
            i_ack = 1'b0;
            if (rst_n && o_cs) begin
                if (wcnt >= ((o_addr == 16'h00FF) ? 3 : 0)) begin
                    i_ack = 1'b1;
                    i_dat = mem[o_addr];
                    if (o_we) mem[o_addr] = o_dat;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [15:0] a, input string tag);
        int n;
        n = 0;
        while (!(o_cs === 1'b1 && o_addr === a) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {15'h0, (o_cs === 1'b1 && o_addr === a)}, 16'h0001);
    endtask

    initial begin
        rst_n = 1'b1;
        i_irq = 4'b0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;
        mem[16'h0000] = f_ldi(10'h3FF, 4'd0);
        mem[16'h0001] = f_ldh(8'hAB, 4'd0);
        mem[16'h0002] = f_ldi(10'h100, 4'd0);
        mem[16'h0003] = f_ld(5'h1F, 4'd0, 4'd1);
        mem[16'h0004] = f_ldi(10'h200, 4'd14);
        mem[16'h0005] = f_ldi(10'h000, 4'd2);
        mem[16'h0006] = f_ldh(8'h04, 4'd2);
        mem[16'h0007] = f_st(5'h02, 4'd0, 4'd1);
        mem[16'h0008] = f_rjp(9'h006, 3'd0);
        mem[16'h000C] = f_ldi(10'h001, 4'd13);
        mem[16'h000F] = f_rjp(9'h1FC, 3'd2);
        mem[16'h0010] = f_ldi(10'h020, 4'd3);
        mem[16'h0011] = f_jp(3'd5, 4'd3);
        mem[16'h0012] = f_jp(3'd1, 4'd3);
        mem[16'h0020] = f_br(3'd0, 4'd2);
        mem[16'h0021] = f_ldi(10'h01C, 4'd13);
        mem[16'h0022] = 16'hFFFF;
        mem[16'h0023] = f_st(5'h1F, 4'd0, 4'd1);
        mem[16'h00FF] = 16'h5A5A;
        mem[16'h0300] = 16'hD170;
        mem[16'h0400] = 16'hD070;

        #3 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cs",      {15'h0, o_cs}, 16'h0000);
        chk("rst_we",      {15'h0, o_we}, 16'h0000);
        chk("rst_addr",    o_addr, 16'h0000);
        chk("rst_dat",     o_dat, 16'h0000);
        chk("rst_irq_ack", {12'h0, o_irq_ack}, 16'h0000);
        chk("rst_halt",    {15'h0, o_halt}, 16'h0000);
        chk("rst_pc",      dut.r_regs[15], 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // ld imm forms: one exec cycle each, no bus in exec
        tick();
        chk("fetch0_addr", o_addr, 16'h0000);
        chk("fetch0_cs",   {15'h0, o_cs}, 16'h0001);
        tick();
        chk("ldi_exec_cs", {15'h0, o_cs}, 16'h0000);
        tick();
        chk("fetch1_addr", o_addr, 16'h0001);
        tick();
        chk("ldh_exec_cs", {15'h0, o_cs}, 16'h0000);
        tick();
        chk("fetch2_addr", o_addr, 16'h0002);
        chk("r0_abff",     dut.r_regs[0], 16'hABFF);

        // ld R1,(R0-1) with three wait states
        wait_addr(16'h00FF, "ld_reach");
        chk("ld_we", {15'h0, o_we}, 16'h0000);
        tick();
        chk("ld_hold1", o_addr, 16'h00FF);
        tick();
        chk("ld_hold2", o_addr, 16'h00FF);
        tick();
        chk("ld_hold3", o_addr, 16'h00FF);
        wait_addr(16'h0004, "fetch4_reach");
        chk("r1_ld", dut.r_regs[1], 16'h5A5A);

        wait_addr(16'h0008, "fetch8_reach");
        chk("st_mem",  mem[16'h0102], 16'h5A5A);
        chk("sp_init", dut.r_regs[14], 16'h0200);
        chk("r2_init", dut.r_regs[2], 16'h0400);

        // rjp NZ -4 from PC=0x0010: taken with Z=0, not taken with Z=1
        wait_addr(16'h000F, "rjp1_reach");
        tick();
        tick();
        chk("rjp_taken", o_addr, 16'h000C);
        wait_addr(16'h000F, "rjp2_reach");
        chk("st_z", dut.r_regs[13], 16'h0001);
        tick();
        tick();
        chk("rjp_not_taken", o_addr, 16'h0010);

        // jp never falls through, jp Z taken
        wait_addr(16'h0012, "jp_never");
        tick();
        tick();
        chk("jp_z_taken", o_addr, 16'h0020);

        // br / ret
        tick();
        chk("br_we",   {15'h0, o_we}, 16'h0001);
        chk("br_addr", o_addr, 16'h0200);
        chk("br_dat",  o_dat, 16'h0021);
        tick();
        chk("br_target", o_addr, 16'h0400);
        chk("br_sp",     dut.r_regs[14], 16'h0201);
        chk("br_mem",    mem[16'h0200], 16'h0021);
        tick();
        chk("ret_addr", o_addr, 16'h0200);
        chk("ret_we",   {15'h0, o_we}, 16'h0000);
        tick();
        chk("ret_pc", o_addr, 16'h0021);
        chk("ret_sp", dut.r_regs[14], 16'h0200);

        // interrupt entry, priority, reti with a still-pending line
        i_irq = 4'b0011;
        tick();
        tick();
        chk("irq_nofetch", {15'h0, o_cs}, 16'h0000);
        tick();
        chk("int_addr", o_addr, 16'h0200);
        chk("int_dat",  o_dat, 16'h0022);
        chk("int_we",   {15'h0, o_we}, 16'h0001);
        chk("int_ack0", {12'h0, o_irq_ack}, 16'h0001);
        i_irq = 4'b0010;
        tick();
        chk("int_vec",      o_addr, 16'h0300);
        chk("int_ack_off",  {12'h0, o_irq_ack}, 16'h0000);
        chk("int_st",       dut.r_regs[13], 16'h0018);
        chk("int_sp",       dut.r_regs[14], 16'h0201);
        tick();
        chk("reti_addr", o_addr, 16'h0200);
        tick();
        chk("reti_nofetch", {15'h0, o_cs}, 16'h0000);
        chk("reti_ie",      dut.r_regs[13], 16'h001C);
        chk("reti_pc",      dut.r_regs[15], 16'h0022);
        tick();
        chk("int2_ack1", {12'h0, o_irq_ack}, 16'h0002);
        chk("int2_dat",  o_dat, 16'h0022);
        i_irq = 4'b0000;
        tick();
        chk("int2_vec", o_addr, 16'h0300);
        tick();
        tick();
        chk("resume_pc", o_addr, 16'h0022);

`ifdef DCPU_HALT_EN
        tick();
        tick();
        chk("halt_on", {15'h0, o_halt}, 16'h0001);
        chk("halt_cs", {15'h0, o_cs}, 16'h0000);
        tick();
        chk("halt_stay", {15'h0, o_halt}, 16'h0001);
        i_irq = 4'b0001;
        tick();
        chk("halt_off", {15'h0, o_halt}, 16'h0000);
        tick();
        chk("halt_int_dat", o_dat, 16'h0023);
        chk("halt_int_ack", {12'h0, o_irq_ack}, 16'h0001);
        i_irq = 4'b0000;
        wait_addr(16'h0023, "halt_resume");
`else
        tick();
        tick();
        chk("ffff_nop", o_addr, 16'h0023);
        chk("halt_tied", {15'h0, o_halt}, 16'h0000);
`endif

        // reset in the middle of a waited store
        wait_addr(16'h00FF, "st_slow_reach");
        chk("st_slow_we", {15'h0, o_we}, 16'h0001);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_cs",   {15'h0, o_cs}, 16'h0000);
        chk("abort_addr", o_addr, 16'h0000);
        chk("abort_pc",   dut.r_regs[15], 16'h0000);
        chk("abort_r1",   dut.r_regs[1], 16'h0000);
        chk("abort_st",   dut.r_regs[13], 16'h0000);
        tick();
        chk("abort_mem",  mem[16'h00FF], 16'h5A5A);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("restart_addr", o_addr, 16'h0000);
        chk("restart_cs",   {15'h0, o_cs}, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
